// File: rtl/led_scan_driver.sv
// HUB75-style LED panel scanner: fetches 24-bit pixels from the RAM read port and
// drives the panel with binary-coded modulation, one bit-plane per colour bit, LSB first.
module led_scan_driver #(
    parameter int COLS       = 32,
    parameter int ROWS       = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int BITS       = 8,
    parameter int BASE_TICKS = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    output logic [ADDR_WIDTH-1:0]       ram_addr,
    input  logic [3*BITS-1:0]           ram_q,
    output logic                        led_clk,
    output logic                        led_lat,
    output logic                        led_oe_n,
    output logic [$clog2(ROWS/2)-1:0]   led_row,
    output logic                        led_r1,
    output logic                        led_g1,
    output logic                        led_b1,
    output logic                        led_r2,
    output logic                        led_g2,
    output logic                        led_b2,
    output logic                        frame_done
);
    localparam int SCAN  = ROWS / 2;
    localparam int ROW_W = $clog2(SCAN);
    localparam int COL_W = $clog2(COLS);
    localparam int PL_W  = $clog2(BITS);
    localparam int CNT_W = $clog2(BASE_TICKS) + BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_TRAIL,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t             st_q, st_d;
    logic [1:0]         ph_q, ph_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [PL_W-1:0]    pl_q, pl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  led_clk_q, led_clk_d;
    logic                  led_lat_q, led_lat_d;
    logic                  led_oe_n_q, led_oe_n_d;
    logic [ROW_W-1:0]      led_row_q, led_row_d;
    logic [2:0]            rgb1_q, rgb1_d;
    logic [2:0]            rgb2_q, rgb2_d;
    logic                  frame_done_q, frame_done_d;

    logic [BITS-1:0] pix_r, pix_g, pix_b;

    assign pix_r = ram_q[3*BITS-1:2*BITS];
    assign pix_g = ram_q[2*BITS-1:BITS];
    assign pix_b = ram_q[BITS-1:0];

    function automatic logic [ADDR_WIDTH-1:0] pix_addr(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col,
        input logic             lower
    );
        logic [ADDR_WIDTH-1:0] r;
        r = ADDR_WIDTH'(row) + (lower ? ADDR_WIDTH'(SCAN) : '0);
        return r * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(col);
    endfunction

    // Sequencing: next scan position, plane and display countdown.
    always_comb begin
        st_d         = st_q;
        ph_d         = ph_q;
        col_d        = col_q;
        row_d        = row_q;
        pl_d         = pl_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        case (st_q)
            S_IDLE: begin
                if (enable) begin
                    st_d  = S_SHIFT;
                    ph_d  = 2'd0;
                    col_d = '0;
                    row_d = '0;
                    pl_d  = '0;
                end
            end
            S_SHIFT: begin
                ph_d = ph_q + 2'd1;
                if (ph_q == 2'd3) begin
                    if (col_q == COL_W'(COLS - 1)) begin
                        st_d  = S_TRAIL;
                        col_d = '0;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            S_TRAIL: st_d = S_LATCH;
            S_LATCH: begin
                st_d  = S_DISPLAY;
                cnt_d = (CNT_W'(BASE_TICKS) << pl_q) - CNT_W'(1);
            end
            S_DISPLAY: begin
                if (cnt_q == '0) begin
                    if (pl_q != PL_W'(BITS - 1)) begin
                        pl_d = pl_q + PL_W'(1);
                        st_d = S_SHIFT;
                    end else if (row_q != ROW_W'(SCAN - 1)) begin
                        row_d = row_q + ROW_W'(1);
                        pl_d  = '0;
                        st_d  = S_SHIFT;
                    end else begin
                        // The IDLE visit doubles as the frame_done cycle and the enable sample point.
                        row_d        = '0;
                        pl_d         = '0;
                        st_d         = S_IDLE;
                        frame_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    // Outputs are derived from the next state so each register shows the current cycle's value.
    always_comb begin
        ram_addr_d = ram_addr_q;
        led_row_d  = led_row_q;
        rgb1_d     = rgb1_q;
        rgb2_d     = rgb2_q;
        if (st_d == S_SHIFT && ph_d == 2'd0) begin
            ram_addr_d = pix_addr(row_d, col_d, 1'b0);
        end else if (st_d == S_SHIFT && ph_d == 2'd1) begin
            ram_addr_d = pix_addr(row_d, col_d, 1'b1);
        end
        led_clk_d  = (st_d == S_SHIFT && ph_d == 2'd0 && col_d != '0) || (st_d == S_TRAIL);
        led_lat_d  = (st_d == S_LATCH);
        led_oe_n_d = (st_d != S_DISPLAY);
        if (st_d == S_LATCH) begin
            led_row_d = row_d;
        end
        // ram_q carries the upper pixel during P1 and the lower pixel during P2.
        if (st_q == S_SHIFT && ph_q == 2'd1) begin
            rgb1_d = {pix_r[pl_q], pix_g[pl_q], pix_b[pl_q]};
        end
        if (st_q == S_SHIFT && ph_q == 2'd2) begin
            rgb2_d = {pix_r[pl_q], pix_g[pl_q], pix_b[pl_q]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q         <= S_IDLE;
            ph_q         <= 2'd0;
            col_q        <= '0;
            row_q        <= '0;
            pl_q         <= '0;
            cnt_q        <= '0;
            ram_addr_q   <= '0;
            led_clk_q    <= 1'b0;
            led_lat_q    <= 1'b0;
            led_oe_n_q   <= 1'b1;
            led_row_q    <= '0;
            rgb1_q       <= 3'b000;
            rgb2_q       <= 3'b000;
            frame_done_q <= 1'b0;
        end else begin
            st_q         <= st_d;
            ph_q         <= ph_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pl_q         <= pl_d;
            cnt_q        <= cnt_d;
            ram_addr_q   <= ram_addr_d;
            led_clk_q    <= led_clk_d;
            led_lat_q    <= led_lat_d;
            led_oe_n_q   <= led_oe_n_d;
            led_row_q    <= led_row_d;
            rgb1_q       <= rgb1_d;
            rgb2_q       <= rgb2_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign led_clk    = led_clk_q;
    assign led_lat    = led_lat_q;
    assign led_oe_n   = led_oe_n_q;
    assign led_row    = led_row_q;
    assign led_r1     = rgb1_q[2];
    assign led_g1     = rgb1_q[1];
    assign led_b1     = rgb1_q[0];
    assign led_r2     = rgb2_q[2];
    assign led_g2     = rgb2_q[1];
    assign led_b2     = rgb2_q[0];
    assign frame_done = frame_done_q;

endmodule

// File: doc/led_scan_driver.md
Name: led_scan_driver

Overview:
- Downstream consumer of the dual-port pixel RAM: reads 24-bit pixels through one read port and drives a 1/(ROWS/2)-scan HUB75-style LED panel.
- Brightness comes from binary-coded modulation (BCM), one bit-plane per colour bit, LSB first.
- Runs entirely in the LED-side clock domain, which is also the RAM read-port clock. The LCD-side writer lives on the other RAM port and is out of scope.

Parameters:
- COLS, 32, panel columns shifted per scan row.
- ROWS, 16, panel rows. Scan rows = ROWS/2; upper and lower halves are driven together.
- ADDR_WIDTH, 9, RAM address width. Requires ROWS*COLS <= 2**ADDR_WIDTH.
- BITS, 8, bits per colour channel. Pixel layout is R=[23:16], G=[15:8], B=[7:0].
- BASE_TICKS, 1, display cycles for bit-plane 0. Plane p displays for BASE_TICKS<<p cycles.

Ports:
- clk  in  1  single clock; also clocks the RAM read port
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  run request
- ram_addr  out  ADDR_WIDTH  RAM read address (registered)
- ram_q  in  3*BITS  RAM read data; one-cycle registered latency
- led_clk  out  1  panel shift clock
- led_lat  out  1  panel latch strobe
- led_oe_n  out  1  panel output enable, active-low
- led_row  out  $clog2(ROWS/2)  scan row address
- led_r1, led_g1, led_b1  out  1 each  upper-half colour bits
- led_r2, led_g2, led_b2  out  1 each  lower-half colour bits
- frame_done  out  1  one-cycle pulse at the end of each frame

Behaviour:
- All outputs are registered.
- Reset (reset_n=0 at a clk edge, including mid-operation) forces: ram_addr=0, led_clk=0, led_lat=0, led_oe_n=1, led_row=0, all colour bits 0, frame_done=0. State returns to IDLE with row=0, plane=0, col=0.
- RAM timing: the address driven in cycle N appears on ram_q in cycle N+1.
- Addressing:
  - upper = row*COLS + col
  - lower = (row+ROWS/2)*COLS + col
  - Column 0 is shifted first.
- States: IDLE, SHIFT, TRAIL, LATCH, DISPLAY.
- IDLE: led_oe_n=1. Moves to SHIFT (row 0, plane 0, col 0) on the cycle after enable is seen high.
- SHIFT: one 4-cycle slot per column, phases P0..P3.
  - P0: ram_addr=upper. led_clk=1 if col>0 (clocks in the previous column), otherwise 0.
  - P1: ram_addr=lower, led_clk=0. At the end of P1, r1/g1/b1 are loaded with ram_q bit p of R/G/B.
  - P2: at the end of P2, r2/g2/b2 are loaded likewise.
  - P3: colour outputs are stable, led_clk=0. After col=COLS-1 P3, go to TRAIL; otherwise col+1, P0.
- TRAIL: 1 cycle, led_clk=1 (clocks the last column). Colour outputs hold.
- LATCH: 1 cycle, led_lat=1, led_clk=0, led_oe_n=1. led_row takes the current row here.
- DISPLAY: led_oe_n=0 for exactly BASE_TICKS<<p cycles. Then:
  - if p<BITS-1: p+1, go to SHIFT.
  - else if row<ROWS/2-1: row+1, p=0, go to SHIFT.
  - else (last plane of last row): frame_done=1 for the single following cycle; row=0, p=0. Go to SHIFT if enable=1, else IDLE.
- led_oe_n is 1 in every state except DISPLAY, so no pixel is lit during shift or row change.
- enable is sampled only in IDLE and at the frame boundary. Deasserting it mid-frame completes the frame.
- Cycles per plane = 4*COLS + 2 + (BASE_TICKS<<p).
- Frame length = (ROWS/2) * (BITS*(4*COLS+2) + BASE_TICKS*(2**BITS-1)) cycles, plus 1 frame_done cycle. Defaults give 8*(8*130+255) = 10360, plus 1.
- The block never writes the RAM.

Test Plan:
- Hold reset_n=0 for 3 cycles mid-DISPLAY → next edge: led_oe_n=1, led_row=0, led_clk=0, ram_addr=0; restart after enable shows ram_addr=0 on the first SHIFT P0.
- With enable=1 from reset and a model RAM, check the first two column slots: ram_addr sequence 0,256,(hold),(hold),1,257; led_clk high on the cycle of ram_addr=1 and in the TRAIL cycle.
- Preload addr 0 = 0x80_01_FF and addr 256 = 0x01_80_00; plane 0 → r1=0,g1=1,b1=1, r2=1,g2=0,b2=0 at column 0's rising led_clk; plane 7 → r1=1,g1=0,b1=1, r2=0,g2=1,b2=0.
- BASE_TICKS=1, BITS=8 → led_oe_n low runs of 1,2,4,...,128 cycles per row, each preceded by exactly one led_lat pulse; led_oe_n never low while led_lat=1 or led_clk=1.
- Free-run: frame_done pulses every 10361 cycles; led_row steps 0..7 and wraps to 0 with no skipped row.
- Drop enable mid-frame → frame completes, frame_done pulses, then block sits in IDLE with led_oe_n=1; raise enable → restarts at row 0, plane 0.
